// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_pkg
// Purpose  : Shared types and helpers for the clock-enable / reset sequencer.
//            state_e  - sequencer states (HOLD, STRETCH, REL, RUN)
//            cause_e  - recorded cause of the most recent reset
//            cnt_width- width of a counter that must reach max(a,b)-1
// Revision : 1.0  initial release
// ============================================================================
package clk_rst_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        REL     = 2'd2,
        RUN     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_EXT  = 2'd0,
        CAUSE_LOCK = 2'd1,
        CAUSE_SOFT = 2'd2
    } cause_e;

    // One shared counter times both the stretch and the stagger intervals,
    // so it must count up to the larger of the two minus one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_rst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_ctrl_if
// Purpose  : Control/status bundle of the reset sequencer.
//            locked_i   - PLL lock (asynchronous to the clock)
//            soft_rst_i - single-cycle soft reset request
//            div_i      - clock-enable divide ratio (0 treated as 1)
//            clken_o    - one-cycle enable pulse every div cycles
//            rst_n_o    - per-domain active-low resets
//            busy_o     - high while any domain is still held in reset
//            cause_o    - cause of the last reset
//            master: drives the requests (SoC / testbench side)
//            slave : the sequencer itself
// Revision : 1.0  initial release
// ============================================================================
interface clk_rst_ctrl_if #(
    parameter int NCH   = 3,
    parameter int DIV_W = 4
);
    logic             locked_i;
    logic             soft_rst_i;
    logic [DIV_W-1:0] div_i;
    logic             clken_o;
    logic [NCH-1:0]   rst_n_o;
    logic             busy_o;
    logic [1:0]       cause_o;

    modport master (
        output locked_i, soft_rst_i, div_i,
        input  clken_o, rst_n_o, busy_o, cause_o
    );

    modport slave (
        input  locked_i, soft_rst_i, div_i,
        output clken_o, rst_n_o, busy_o, cause_o
    );
endinterface
`default_nettype wire

// File: rtl/sync_nff.sv
`default_nettype none
// ============================================================================
// Module   : sync_nff
// Purpose  : N-flop synchroniser for a single asynchronous input bit.
//            clk - destination clock
//            rst - asynchronous active-high clear (output forced low)
//            d   - asynchronous input
//            q   - synchronised output, STAGES clock edges of latency
// Revision : 1.0  initial release
// ============================================================================
module sync_nff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_ctrl
// Purpose  : Reset sequencer and clock-enable generator between the PLL and
//            the SoC. Synchronises PLL lock, stretches and staggers NCH
//            active-low resets, records the last reset cause and produces a
//            programmable-ratio clock-enable pulse.
//            clk_i - PLL output clock
//            rst_i - asynchronous active-high reset
//            bus   - clk_rst_ctrl_if.slave (lock, soft reset, divider,
//                    clken, per-domain resets, busy, cause)
// Revision : 1.0  initial release
// ============================================================================
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int DLY         = 255,
    parameter int STAGGER     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 4
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    clk_rst_ctrl_if.slave  bus
);

    localparam int CW  = cnt_width(DLY, STAGGER);
    localparam int CHW = $clog2(NCH + 1);

    localparam logic [CW-1:0]  c_dly_last = CW'(DLY - 1);
    localparam logic [CW-1:0]  c_stg_last = CW'(STAGGER - 1);
    localparam logic [CHW-1:0] c_ch_last  = CHW'(NCH - 1);

    logic w_lock_s;

    state_e           r_state, w_state;
    logic [CW-1:0]    r_cnt,   w_cnt;
    logic [CHW-1:0]   r_ch,    w_ch;
    logic [NCH-1:0]   r_rst_n, w_rst_n;
    logic             r_busy,  w_busy;
    cause_e           r_cause, w_cause;

    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] r_dc;
    logic             r_clken;
    logic [DIV_W-1:0] w_div_in;
    logic [DIV_W-1:0] w_div_last;

    sync_nff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (bus.locked_i),
        .q   (w_lock_s)
    );

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= HOLD;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_cause <= CAUSE_EXT;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ch    <= w_ch;
            r_rst_n <= w_rst_n;
            r_busy  <= w_busy;
            r_cause <= w_cause;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ch    = r_ch;
        w_rst_n = r_rst_n;
        w_cause = r_cause;

        case (r_state)
            HOLD: begin
                w_rst_n = '0;
                if (w_lock_s) begin
                    w_state = STRETCH;
                    w_cnt   = '0;
                end
            end

            STRETCH: begin
                if (!w_lock_s) begin
                    w_state = HOLD;
                    w_rst_n = '0;
                    w_cnt   = '0;
                    w_cause = CAUSE_LOCK;
                end else if (r_cnt == c_dly_last) begin
                    w_rst_n[0] = 1'b1;
                    w_ch       = CHW'(1);
                    w_cnt      = '0;
                    w_state    = (NCH > 1) ? REL : RUN;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            REL: begin
                if (!w_lock_s) begin
                    w_state = HOLD;
                    w_rst_n = '0;
                    w_cnt   = '0;
                    w_cause = CAUSE_LOCK;
                end else if (r_cnt == c_stg_last) begin
                    // Release exactly the channel addressed by r_ch.
                    for (int k = 0; k < NCH; k++) begin
                        if (r_ch == CHW'(k)) begin
                            w_rst_n[k] = 1'b1;
                        end
                    end
                    w_cnt = '0;
                    w_ch  = r_ch + 1'b1;
                    if (r_ch == c_ch_last) begin
                        w_state = RUN;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            RUN: begin
                w_rst_n = '1;
                // Lock loss is checked first so it wins over a soft request.
                if (!w_lock_s) begin
                    w_state = HOLD;
                    w_rst_n = '0;
                    w_cnt   = '0;
                    w_cause = CAUSE_LOCK;
                end else if (bus.soft_rst_i) begin
                    w_state = HOLD;
                    w_rst_n = '0;
                    w_cnt   = '0;
                    w_cause = CAUSE_SOFT;
                end
            end

            default: begin
                w_state = HOLD;
                w_rst_n = '0;
            end
        endcase
    end

    // busy is registered alongside rst_n so the two never disagree.
    assign w_busy = ~&w_rst_n;

    // ------------------------------------------------------------------
    // Clock-enable divider
    // ------------------------------------------------------------------
    assign w_div_in   = (bus.div_i == '0) ? DIV_W'(1) : bus.div_i;
    assign w_div_last = r_div_q - DIV_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div_q <= DIV_W'(1);
            r_dc    <= '0;
            r_clken <= 1'b0;
        end else begin
            if (r_state == HOLD) begin
                r_div_q <= w_div_in;
            end
            // A soft reset re-enters HOLD with lock still high, so the ratio
            // can shrink while dc is mid-count; wrapping on >= keeps dc from
            // running past the new terminal value.
            if (!w_lock_s) begin
                r_dc    <= '0;
                r_clken <= 1'b0;
            end else if (r_dc >= w_div_last) begin
                r_dc    <= '0;
                r_clken <= 1'b1;
            end else begin
                r_dc    <= r_dc + 1'b1;
                r_clken <= 1'b0;
            end
        end
    end

    assign bus.clken_o = r_clken;
    assign bus.rst_n_o = r_rst_n;
    assign bus.busy_o  = r_busy;
    assign bus.cause_o = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_rst_ctrl
// Purpose  : Self-checking bench for clk_rst_ctrl. A driver issues directed
//            and random stimulus at each falling edge and pushes the expected
//            post-edge response, computed by a timeline-level reference
//            model, into a scoreboard queue; a monitor pops and compares
//            after each rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_rst_ctrl;

    localparam int NCH         = 3;
    localparam int DLY         = 8;
    localparam int STAGGER     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DIV_W       = 4;
    localparam int LAST        = DLY + (NCH - 1) * STAGGER;

    logic clk;
    logic rst;
    logic rst_req;

    clk_rst_ctrl_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

    clk_rst_ctrl #(
        .NCH         (NCH),
        .DLY         (DLY),
        .STAGGER     (STAGGER),
        .SYNC_STAGES (SYNC_STAGES),
        .DIV_W       (DIV_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    typedef struct {
        bit             rst;
        logic [NCH-1:0] rst_n;
        bit             busy;
        logic [1:0]     cause;
        bit             lock_edge;
        bit             hold_latch;
        int             div;
    } exp_t;

    exp_t sb[$];

    // ---------------- reference model (timeline level) ----------------
    // m_started : sequence running since the lock edge; m_t counts edges
    // since then. Channel k is out of reset once m_t >= DLY + k*STAGGER.
    bit m_started;
    int m_t;
    int m_cause;
    int m_div;
    bit m_sync [SYNC_STAGES];

    task automatic model_reset();
        m_started = 0;
        m_t       = 0;
        m_cause   = 0;
        m_div     = 1;
        for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 0;
    endtask

    function automatic bit model_lock_s();
        return m_sync[SYNC_STAGES-1];
    endfunction

    task automatic push_reset();
        exp_t e;
        e.rst = 1; e.rst_n = '0; e.busy = 1; e.cause = 2'd0;
        e.lock_edge = 0; e.hold_latch = 0; e.div = 1;
        sb.push_back(e);
    endtask

    task automatic model_step();
        exp_t e;
        bit   ls;
        bit   hold_now;
        ls       = m_sync[SYNC_STAGES-1];
        hold_now = !m_started;
        if (hold_now) m_div = (bus.div_i == 0) ? 1 : int'(bus.div_i);
        if (m_started) begin
            if (!ls) begin
                m_started = 0; m_cause = 1;
            end else if (bus.soft_rst_i && m_t >= LAST) begin
                m_started = 0; m_cause = 2;
            end else if (m_t < LAST) begin
                m_t++;
            end
        end else if (ls) begin
            m_started = 1; m_t = 0;
        end
        for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = bus.locked_i;

        e.rst = 0;
        for (int k = 0; k < NCH; k++) e.rst_n[k] = m_started && (m_t >= DLY + k * STAGGER);
        e.busy       = !(&e.rst_n);
        e.cause      = 2'(m_cause);
        e.lock_edge  = ls;
        e.hold_latch = hold_now;
        e.div        = m_div;
        sb.push_back(e);
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick(input bit lk, input bit sf, input int dv);
        @(negedge clk);
        bus.locked_i   = lk;
        bus.soft_rst_i = sf;
        bus.div_i      = DIV_W'(dv);
        if (!rst_req && rst) rst = 0;
        if (rst) push_reset();
        else     model_step();
    endtask

    // Assert rst_i between edges and check the outputs react at once.
    task automatic async_reset(input int dv);
        @(negedge clk);
        bus.soft_rst_i = 0;
        bus.div_i      = DIV_W'(dv);
        #2;
        rst     = 1;
        rst_req = 1;
        #1;
        chk("async_rst_n", 32'(bus.rst_n_o), 32'd0);
        chk("async_busy",  32'(bus.busy_o),  32'd1);
        chk("async_clken", 32'(bus.clken_o), 32'd0);
        chk("async_cause", 32'(bus.cause_o), 32'd0);
        model_reset();
        push_reset();
    endtask

    function automatic bit model_in_run();
        return m_started && m_t >= LAST;
    endfunction

    function automatic bit model_in_rel();
        return m_started && m_t >= DLY && m_t < LAST;
    endfunction

    int cur_div;

    task automatic run_until_run(input int budget);
        int n;
        n = 0;
        while (!model_in_run() && n < budget) begin
            tick(1, 0, cur_div);
            n++;
        end
        n_checks++;
        if (!model_in_run()) begin
            n_errors++;
            $display("FAIL run_until_run: budget %0d expired", budget);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        int   cyc;
        int   last;
        cyc  = 0;
        last = -1;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                cyc++;
                chk("rst_n", 32'(bus.rst_n_o), 32'(e.rst_n));
                chk("busy",  32'(bus.busy_o),  32'(e.busy));
                chk("cause", 32'(bus.cause_o), 32'(e.cause));
                if (e.rst || !e.lock_edge) begin
                    chk("clken_idle", 32'(bus.clken_o), 32'd0);
                    last = -1;
                end else if (e.hold_latch) begin
                    last = -1;
                end else begin
                    if (last >= 0 && cyc - last <= e.div)
                        chk("clken_period", 32'(bus.clken_o), 32'((cyc - last) == e.div));
                    if (bus.clken_o === 1'b1) last = cyc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1;
        rst_req        = 1;
        bus.locked_i   = 0;
        bus.soft_rst_i = 0;
        bus.div_i      = '0;
        cur_div        = 5;
        model_reset();
        #1;
        chk("por_rst_n", 32'(bus.rst_n_o), 32'd0);
        chk("por_busy",  32'(bus.busy_o),  32'd1);
        chk("por_clken", 32'(bus.clken_o), 32'd0);
        chk("por_cause", 32'(bus.cause_o), 32'd0);

        // Power-up sequence with div 5
        rst_req = 0;
        run_until_run(60);
        repeat (20) tick(1, 0, cur_div);

        // Ratio change while running must not take effect until HOLD
        cur_div = 3;
        repeat (20) tick(1, 0, cur_div);

        // Soft reset in RUN; sequence replays with ratio 3
        tick(1, 1, cur_div);
        run_until_run(60);
        repeat (15) tick(1, 0, cur_div);

        // One-cycle lock drop in RUN
        tick(0, 0, cur_div);
        run_until_run(60);
        repeat (6) tick(1, 0, cur_div);

        // Soft reset during REL is ignored
        while (!model_in_rel()) tick(1, 0, cur_div);
        tick(1, 1, cur_div);
        run_until_run(60);
        repeat (4) tick(1, 0, cur_div);

        // Soft request coincident with lock_s falling: lock loss wins
        tick(0, 0, cur_div);
        repeat (SYNC_STAGES + 2) tick(1, (model_lock_s() == 0), cur_div);
        run_until_run(60);

        // Divide ratio 0 behaves as 1
        cur_div = 0;
        tick(1, 1, cur_div);
        run_until_run(60);
        repeat (12) tick(1, 0, cur_div);

        // Async reset mid-REL, then restart
        cur_div = 4;
        tick(1, 1, cur_div);
        while (!model_in_rel()) tick(1, 0, cur_div);
        tick(1, 0, cur_div);
        async_reset(cur_div);
        tick(1, 0, cur_div);
        rst_req = 0;
        run_until_run(60);
        repeat (10) tick(1, 0, cur_div);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            bit lk;
            bit sf;
            if ($urandom_range(0, 39) == 0) cur_div = int'($urandom_range(0, 15));
            lk = ($urandom_range(0, 59) != 0);
            sf = ($urandom_range(0, 29) == 0);
            tick(lk, sf, cur_div);
        end

        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
